progmem: RTL

Parametrised program memory for the CPU data path, succeeding the fixed 64-word instruction store. It provides a registered fetch port for the instruction-fetch stage and a streaming load port with valid/ready handshake, so a program image is written from outside instead of being hard-coded. After reset, a sequencer zero-fills the array, and out-of-range accesses are flagged instead of aliasing.

---
 rtl/progmem.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/progmem.sv
// progmem: parametrised program memory with a registered fetch port and a
// valid/ready streaming load port. After reset a sequencer zero-fills the
// array, then the block idles until an image load or fetches arrive.
module progmem #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_ready,
    output logic              fetch_valid,
    output logic [DATA_W-1:0] fetch_data,
    output logic              fetch_fault,
    input  logic              load_start,
    input  logic [ADDR_W-1:0] load_base,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    output logic              load_ready,
    output logic              busy,
    output logic              load_done,
    output logic              load_err
);

    // Width of the physical array index; a one-word array still needs one bit.
    localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Pointers and bounds carry one extra bit so DEPTH = 2^ADDR_W cannot wrap.
    localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] LAST_X  = (ADDR_W+1)'(DEPTH - 1);

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_IDLE  = 2'd1,
        ST_LOAD  = 2'd2
    } state_t;

    state_t state_q;

    logic [ADDR_W:0] clr_ptr_q;
    logic [ADDR_W:0] wr_ptr_q;
    logic            busy_q;
    logic            load_ready_q;
    logic            fetch_ready_q;
    logic            load_done_q;
    logic            load_err_q;

    logic              fetch_valid_q;
    logic              fetch_fault_q;
    logic [DATA_W-1:0] fetch_data_q;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              mem_we_d;
    logic [ADDR_W:0]   mem_waddr_d;
    logic [DATA_W-1:0] mem_wdata_d;

    logic            fetch_acc;
    logic            fetch_in_range;
    logic            base_in_range;

    assign fetch_acc      = fetch_req & fetch_ready_q;
    assign fetch_in_range = ({1'b0, fetch_addr} < DEPTH_X);
    assign base_in_range  = ({1'b0, load_base} < DEPTH_X);

    // Single write port: the clear sweep and load beats never overlap in time.
    always_comb begin
        mem_we_d    = 1'b0;
        mem_waddr_d = clr_ptr_q;
        mem_wdata_d = '0;
        case (state_q)
            ST_CLEAR: begin
                mem_we_d = 1'b1;
            end
            ST_LOAD: begin
                if (load_valid) begin
                    mem_we_d    = 1'b1;
                    mem_waddr_d = wr_ptr_q;
                    mem_wdata_d = load_data;
                end
            end
            default: begin
                mem_we_d = 1'b0;
            end
        endcase
    end

    // Sequencer: clear sweep, idle, image load; all status outputs registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_CLEAR;
            clr_ptr_q     <= '0;
            wr_ptr_q      <= '0;
            busy_q        <= 1'b1;
            load_ready_q  <= 1'b0;
            fetch_ready_q <= 1'b0;
            load_done_q   <= 1'b0;
            load_err_q    <= 1'b0;
        end else begin
            load_done_q <= 1'b0;
            load_err_q  <= 1'b0;
            case (state_q)
                ST_CLEAR: begin
                    clr_ptr_q <= clr_ptr_q + 1'b1;
                    if (clr_ptr_q == LAST_X) begin
                        state_q       <= ST_IDLE;
                        busy_q        <= 1'b0;
                        fetch_ready_q <= 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (load_start) begin
                        if (base_in_range) begin
                            state_q       <= ST_LOAD;
                            wr_ptr_q      <= {1'b0, load_base};
                            busy_q        <= 1'b1;
                            fetch_ready_q <= 1'b0;
                            load_ready_q  <= 1'b1;
                        end else begin
                            load_err_q <= 1'b1;
                        end
                    end
                end
                ST_LOAD: begin
                    if (load_valid) begin
                        wr_ptr_q <= wr_ptr_q + 1'b1;
                        if (load_last || (wr_ptr_q == LAST_X)) begin
                            state_q       <= ST_IDLE;
                            busy_q        <= 1'b0;
                            fetch_ready_q <= 1'b1;
                            load_ready_q  <= 1'b0;
                            load_done_q   <= load_last;
                            load_err_q    <= ~load_last;
                        end
                    end
                end
                default: begin
                    state_q       <= ST_CLEAR;
                    clr_ptr_q     <= '0;
                    busy_q        <= 1'b1;
                    fetch_ready_q <= 1'b0;
                    load_ready_q  <= 1'b0;
                end
            endcase
        end
    end

    // Array write; no reset so the array maps onto block RAM.
    always_ff @(posedge clk) begin
        if (mem_we_d) begin
            mem[mem_waddr_d[MEM_AW-1:0]] <= mem_wdata_d;
        end
    end

    // Registered fetch: out-of-range addresses return zero and raise a fault.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_valid_q <= 1'b0;
            fetch_fault_q <= 1'b0;
            fetch_data_q  <= '0;
        end else begin
            fetch_valid_q <= fetch_acc;
            fetch_fault_q <= fetch_acc & ~fetch_in_range;
            if (fetch_acc) begin
                fetch_data_q <= fetch_in_range ? mem[fetch_addr[MEM_AW-1:0]] : '0;
            end
        end
    end

    assign fetch_ready = fetch_ready_q;
    assign fetch_valid = fetch_valid_q;
    assign fetch_fault = fetch_fault_q;
    assign fetch_data  = fetch_data_q;
    assign load_ready  = load_ready_q;
    assign busy        = busy_q;
    assign load_done   = load_done_q;
    assign load_err    = load_err_q;

endmodule
